// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative signed divider: FSM encoding,
// default widths and the special operand values used for exception detection.
package seq_divider_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    localparam logic [DEF_WIDTH-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [DEF_WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and keeps the difference only when it does not borrow.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_msb,
    input  logic [WIDTH:0]   i_div_mag,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {i_rem, i_dvd_msb};

    // w_shift < 2*|B| <= 2^WIDTH, so the WIDTH+1-bit difference never
    // overflows and its top bit is a reliable sign.
    assign w_trial = w_shift + ~i_div_mag + (WIDTH+1)'(1);

    assign o_q_bit = ~w_trial[WIDTH];
    assign o_rem   = o_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: 32 restoring steps on operand magnitudes, then a
// sign/exception fix-up cycle; fixed 33-cycle latency from start to done pulse.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH:0]   r_div_mag;
    logic [WIDTH-1:0] r_a_orig;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_div_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_exception;
    logic             r_rdy;

    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_a_mag;
    logic [WIDTH:0]   w_b_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic             w_unused_a_mag_msb;

    // Magnitudes are formed one bit wider so that |INT_MIN| cannot wrap.
    assign w_a_ext = {data_operandA[WIDTH-1], data_operandA};
    assign w_b_ext = {data_operandB[WIDTH-1], data_operandB};
    assign w_a_mag = data_operandA[WIDTH-1] ? (~w_a_ext + (WIDTH+1)'(1)) : w_a_ext;
    assign w_b_mag = data_operandB[WIDTH-1] ? (~w_b_ext + (WIDTH+1)'(1)) : w_b_ext;

    // |A| <= 2^(WIDTH-1), so the extra bit of the dividend magnitude is always 0.
    assign w_unused_a_mag_msb = w_a_mag[WIDTH];

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_dvd_msb(r_dvd[WIDTH-1]),
        .i_div_mag(r_div_mag),
        .o_rem    (w_rem_next),
        .o_q_bit  (w_q_bit)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous and checked first so it wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A start pulse restarts from any state, discarding the operation in flight.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        w_state_next = r_state;
        if (ctrl_DIV) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_IDLE;
                ST_RUN:  w_state_next = (r_cnt == CNT_W'(WIDTH - 1)) ? ST_FIX : ST_RUN;
                ST_FIX:  w_state_next = ST_DONE;
                ST_DONE: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_div_mag   <= '0;
            r_a_orig    <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_div_zero  <= 1'b0;
            r_ovf       <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (ctrl_DIV) begin
                r_a_orig   <= data_operandA;
                r_dvd      <= w_a_mag[WIDTH-1:0];
                r_div_mag  <= w_b_mag;
                r_sign_a   <= data_operandA[WIDTH-1];
                r_sign_b   <= data_operandB[WIDTH-1];
                r_div_zero <= (data_operandB == '0);
                r_ovf      <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
                r_rem      <= '0;
                r_cnt      <= '0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        // Dividend bits leave at the top while quotient bits enter at the bottom.
                        r_rem <= w_rem_next;
                        r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    ST_FIX: begin
                        r_rdy <= 1'b1;
                        if (r_div_zero) begin
                            r_result    <= '0;
                            r_remainder <= r_a_orig;
                            r_exception <= 1'b1;
                        end else if (r_ovf) begin
                            r_result    <= INT_MIN;
                            r_remainder <= '0;
                            r_exception <= 1'b1;
                        end else begin
                            r_result    <= (r_sign_a ^ r_sign_b) ? -r_dvd : r_dvd;
                            r_remainder <= r_sign_a ? -r_rem : r_rem;
                            r_exception <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_remainder = r_remainder;
    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state == ST_RUN) || (r_state == ST_FIX);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed and random operands compared
// against a plain signed-arithmetic reference, plus restart and reset scenarios.
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    localparam int LATENCY = 33;

    localparam logic [31:0] DIR_A [10] = '{
        32'd100, 32'hFFFF_FF9C, 32'd100, 32'd5, 32'h8000_0000,
        32'h7FFF_FFFF, 32'hFFFF_FFF9, 32'd0, 32'h8000_0000, 32'h8000_0000
    };
    localparam logic [31:0] DIR_B [10] = '{
        32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF,
        32'd1, 32'hFFFF_FFFE, 32'd5, 32'd1, 32'd2
    };

    seq_divider #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Reference: signed division truncating toward zero, remainder follows the dividend.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'd0; r = a; e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; e = 1'b1;
        end else begin
            q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
        end
    endfunction

    // Called at a falling edge; the start pulse is sampled on the next rising edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
    endtask

    // Returns the number of rising edges after the start edge until the done pulse, or -1.
    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        checks++; if (data_result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h want 0", data_result); end
        checks++; if (data_remainder !== 32'd0) begin failures++; $display("FAIL reset_remainder: got %h want 0", data_remainder); end
        checks++; if (data_exception !== 1'b0) begin failures++; $display("FAIL reset_exception: got %b want 0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_directed();
        logic [31:0] q, r;
        logic        e;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            model(DIR_A[i], DIR_B[i], q, r, e);
            start_op(DIR_A[i], DIR_B[i]);
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dir%0d busy_run: got %b want 1", i, busy); end
            wait_rdy(lat);
            checks++; if (lat != LATENCY) begin failures++; $display("FAIL dir%0d latency: got %0d want %0d", i, lat, LATENCY); end
            checks++; if (data_result !== q) begin failures++; $display("FAIL dir%0d result: got %h want %h", i, data_result, q); end
            checks++; if (data_remainder !== r) begin failures++; $display("FAIL dir%0d remainder: got %h want %h", i, data_remainder, r); end
            checks++; if (data_exception !== e) begin failures++; $display("FAIL dir%0d exception: got %b want %b", i, data_exception, e); end
            @(negedge clock);
            checks++; if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL dir%0d after_done: got rdy=%b busy=%b want 0 0", i, data_resultRDY, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r;
        logic        e;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom) : (32'($urandom) >>> $urandom_range(8, 24));
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom);
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = 32'($urandom) & 32'h0000_0003;
            endcase
            model(a, b, q, r, e);
            start_op(a, b);
            wait_rdy(lat);
            checks++; if (lat != LATENCY) begin failures++; $display("FAIL rnd%0d latency: got %0d want %0d", i, lat, LATENCY); end
            checks++; if (data_result !== q || data_remainder !== r || data_exception !== e) begin
                failures++;
                $display("FAIL rnd%0d a=%h b=%h: got q=%h r=%h e=%b want q=%h r=%h e=%b",
                         i, a, b, data_result, data_remainder, data_exception, q, r, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_restart_run();
        int early = 0;
        int pulses = 0;
        int lat = -1;
        logic [31:0] got_q, got_r;
        start_op(32'd100, 32'd7);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) early++;
        end
        start_op(32'd81, 32'd9);
        got_q = 'x;
        got_r = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                pulses++;
                if (lat < 0) begin lat = k; got_q = data_result; got_r = data_remainder; end
            end
        end
        checks++; if (early != 0) begin failures++; $display("FAIL restart_early_rdy: got %0d pulses want 0", early); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL restart_pulses: got %0d want 1", pulses); end
        checks++; if (lat != LATENCY) begin failures++; $display("FAIL restart_latency: got %0d want %0d", lat, LATENCY); end
        checks++; if (got_q !== 32'd9 || got_r !== 32'd0) begin
            failures++; $display("FAIL restart_values: got q=%h r=%h want q=9 r=0", got_q, got_r);
        end
    endtask

    task automatic test_restart_fix();
        logic [31:0] q, r;
        logic        e;
        int          lat;
        start_op(32'd1000, 32'd3);
        for (int k = 1; k <= 32; k++) @(negedge clock);
        model(32'hFFFF_FFCE, 32'd6, q, r, e);
        start_op(32'hFFFF_FFCE, 32'd6);
        checks++; if (data_resultRDY !== 1'b0) begin failures++; $display("FAIL fix_restart_rdy: got %b want 0", data_resultRDY); end
        wait_rdy(lat);
        checks++; if (lat != LATENCY) begin failures++; $display("FAIL fix_restart_latency: got %0d want %0d", lat, LATENCY); end
        checks++; if (data_result !== q || data_remainder !== r) begin
            failures++; $display("FAIL fix_restart_values: got q=%h r=%h want q=%h r=%h", data_result, data_remainder, q, r);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, q, r;
        logic        e;
        int          lat;
        a1 = 32'($urandom);
        b1 = 32'($urandom_range(1, 1000));
        a2 = 32'($urandom);
        b2 = 32'd0 - 32'($urandom_range(1, 1000));
        model(a1, b1, q, r, e);
        start_op(a1, b1);
        wait_rdy(lat);
        checks++; if (lat != LATENCY || data_result !== q || data_remainder !== r) begin
            failures++; $display("FAIL b2b_first: got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h", lat, data_result, data_remainder, LATENCY, q, r);
        end
        model(a2, b2, q, r, e);
        start_op(a2, b2);
        checks++; if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_restart: got rdy=%b busy=%b want 0 1", data_resultRDY, busy);
        end
        wait_rdy(lat);
        checks++; if (lat != LATENCY || data_result !== q || data_remainder !== r || data_exception !== e) begin
            failures++; $display("FAIL b2b_second: got lat=%0d q=%h r=%h e=%b want lat=%0d q=%h r=%h e=%b",
                                 lat, data_result, data_remainder, data_exception, LATENCY, q, r, e);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int lat;
        start_op(32'd12345, 32'd67);
        for (int k = 1; k <= 19; k++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (data_result !== 32'd0 || data_remainder !== 32'd0 || data_exception !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs: got q=%h r=%h e=%b want 0 0 0", data_result, data_remainder, data_exception);
        end
        checks++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++; $display("FAIL midreset_state: got busy=%b rdy=%b want 0 0", busy, data_resultRDY);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL midreset_no_rdy: got %0d pulses want 0", pulses); end
        start_op(32'h7FFF_FFFF, 32'd1);
        wait_rdy(lat);
        checks++; if (lat != LATENCY || data_result !== 32'h7FFF_FFFF || data_remainder !== 32'd0) begin
            failures++; $display("FAIL midreset_next: got lat=%0d q=%h r=%h want lat=%0d q=7fffffff r=0", lat, data_result, data_remainder, LATENCY);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_and_start();
        int seen = 0;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        ctrl_DIV = 1'b1;
        reset    = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        reset    = 1'b0;
        checks++; if (data_result !== 32'd0 || data_remainder !== 32'd0 || data_exception !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_start_outputs: got q=%h r=%h e=%b busy=%b want all 0",
                                 data_result, data_remainder, data_exception, busy);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (busy === 1'b1 || data_resultRDY === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_start_idle: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_restart_run();
        test_restart_fix();
        test_back_to_back();
        test_reset_mid();
        test_reset_and_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative signed 32-bit divider for the processor's execute stage; the inverse arithmetic path to the ALU adder.
- Produces quotient and remainder by restoring shift-subtract, one quotient bit per cycle.
- The pipeline stalls on ctrl_DIV until data_resultRDY pulses.

Parameters:
- WIDTH, 32, operand/result width in bits (only 32 is verified).
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ctrl_DIV  input  1  start pulse; operands sampled on the same edge.
- data_operandA  input  WIDTH  dividend, two's complement.
- data_operandB  input  WIDTH  divisor, two's complement.
- data_result  output  WIDTH  quotient, registered.
- data_remainder  output  WIDTH  remainder, registered.
- data_exception  output  1  divide-by-zero or overflow flag, registered.
- data_resultRDY  output  1  single-cycle done pulse.
- busy  output  1  high in RUN and FIX states.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, all internal registers=0; data_result, data_remainder, data_exception, data_resultRDY and busy all 0. Reset overrides ctrl_DIV on the same edge.
- States: IDLE, RUN, FIX, DONE.
- IDLE: on an edge with ctrl_DIV=1:
  - latch |A|, |B|, signA, signB;
  - set the zero-divisor flag (B==0) and the overflow flag (A==0x80000000 and B==0xFFFFFFFF);
  - clear the partial remainder; counter=0; go to RUN.
- RUN: each edge:
  - shift {rem, dvd} left by 1;
  - trial = rem - |B| (WIDTH+1 bits);
  - if trial is non-negative: rem=trial and the new quotient LSB is 1; else rem is unchanged and the LSB is 0;
  - counter++; on the edge where counter reaches WIDTH-1, go to FIX.
- FIX: one edge.
  - Quotient is negated if signA XOR signB; remainder is negated if signA. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Outputs registered, data_resultRDY=1, go to DONE.
- Exception priority in FIX:
  - zero divisor: result=0, remainder=A (the original value), data_exception=1;
  - else overflow: result=0x80000000, remainder=0, data_exception=1;
  - else data_exception=0.
- DONE: lasts one cycle; data_resultRDY falls on the next edge; go to IDLE. data_result and data_remainder hold until the next FIX.
- Latency: ctrl_DIV sampled at edge E0; RUN iterates on E1..E32; FIX at E33. data_resultRDY is high between E33 and E34: exactly 33 cycles, fixed, including exception cases.
- ctrl_DIV in RUN or FIX: restarts. New operands are latched, counter=0, state=RUN, the old operation is discarded and no resultRDY is issued for it.
- ctrl_DIV in DONE: restart is accepted; data_resultRDY still pulses that cycle for the finished operation.
- busy = (state==RUN or state==FIX).
- |0x80000000| is computed in WIDTH+1 bits, so the magnitude path never wraps.

Decomposition:
- Shared package holds:
  - state encoding IDLE/RUN/FIX/DONE;
  - WIDTH default;
  - constants INT_MIN=0x80000000 and NEG_ONE=0xFFFFFFFF.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: rem, dvd MSB, divisor magnitude.
  - Outputs: next rem, quotient bit.
  - The subtract is implemented as an add of the inverted divisor with carry-in 1.

Test Plan:
- A=100, B=7, pulse ctrl_DIV -> after exactly 33 cycles: resultRDY pulse, result=14, remainder=2, exception=0, busy low the following cycle.
- A=-100 (0xFFFFFF9C), B=7 -> result=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE). A=100, B=-7 -> result=-14, remainder=2.
- A=5, B=0 -> result=0, remainder=5, exception=1, same 33-cycle latency. A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=1.
- Start A=100, B=7; at cycle 10 pulse ctrl_DIV with A=81, B=9 -> one resultRDY only, 33 cycles after the second pulse, result=9, remainder=0.
- Start a division; assert reset at cycle 20 -> next cycle all outputs 0, state IDLE, no resultRDY. Then A=0x7FFFFFFF, B=1 -> result=0x7FFFFFFF, remainder=0.
- ctrl_DIV and reset high on the same edge -> stays IDLE, outputs 0.
